// File: rtl/counter_pkg.sv
// Shared constants for the counter_timer block: mode encodings and default widths.
package counter_pkg;

    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_MOD     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_PSC_W = 8;

endpackage

// File: rtl/cnt_prescaler.sv
// Programmable prescaler: emits a combinational tick on every (psc+1)-th enabled cycle.
module cnt_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;

    // >= rather than == so a shrinking psc cannot strand the count above it
    assign tick = en & ~clr & (psc_cnt >= psc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
        end else if (en) begin
            psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/counter_timer.sv
// Loadable up/down counter/timer with prescaler, free-run/modulo/one-shot modes,
// compare-match pulse and sticky overflow flag.
module counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_cnt_en,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_clr,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_top,
    input  logic [WIDTH-1:0] i_cmp,
    input  logic [PSC_W-1:0] i_psc,
    input  logic             i_ovf_ack,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tick,
    output logic             o_ovf_pls,
    output logic             o_ovf_flg,
    output logic             o_cmp_match,
    output logic             o_done
);

    logic             psc_tick;
    logic             is_bounded;
    logic             is_oneshot;
    logic             wrap;
    logic             halt;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] step_val;

    // A finished one-shot freezes the prescaler so the phase is preserved until restart
    cnt_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk  (i_sysclk),
        .rst  (i_sysrst),
        .en   (i_cnt_en & ~o_done),
        .clr  (i_clr | i_ld),
        .psc  (i_psc),
        .tick (psc_tick)
    );

    always_comb begin
        is_oneshot = (i_mode == MODE_ONESHOT);
        is_bounded = (i_mode == MODE_MOD) || is_oneshot;
        max_val    = is_bounded ? i_top : '1;
        wrap       = i_dir ? (o_cnt >= max_val) : (o_cnt == '0);
        halt       = wrap && is_oneshot;
        step_val   = o_cnt;
        if (i_dir) begin
            step_val = wrap ? '0 : o_cnt + WIDTH'(1);
        end else begin
            step_val = wrap ? max_val : o_cnt - WIDTH'(1);
        end
        if (halt) begin
            step_val = o_cnt;
        end
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            o_cnt       <= '0;
            o_tick      <= 1'b0;
            o_ovf_pls   <= 1'b0;
            o_ovf_flg   <= 1'b0;
            o_cmp_match <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_tick      <= 1'b0;
            o_ovf_pls   <= 1'b0;
            o_cmp_match <= 1'b0;
            if (i_clr) begin
                o_cnt  <= '0;
                o_done <= 1'b0;
            end else if (i_ld) begin
                o_cnt       <= i_ld_data;
                o_done      <= 1'b0;
                o_cmp_match <= (i_ld_data == i_cmp);
            end else if (psc_tick) begin
                o_tick      <= 1'b1;
                o_cnt       <= step_val;
                o_ovf_pls   <= wrap;
                o_cmp_match <= !halt && (step_val == i_cmp);
                if (halt) begin
                    o_done <= 1'b1;
                end
            end
            // psc_tick is already masked by clr/ld inside the prescaler
            if (psc_tick && wrap) begin
                o_ovf_flg <= 1'b1;
            end else if (i_ovf_ack) begin
                o_ovf_flg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_timer.sv
// Bench for counter_timer: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_counter_timer;

    localparam int W  = 16;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          ld;
    logic [W-1:0]  ld_data;
    logic          clr;
    logic          dir;
    logic [1:0]    mode;
    logic [W-1:0]  top;
    logic [W-1:0]  cmp;
    logic [PW-1:0] psc;
    logic          ack;
    logic [W-1:0]  cnt;
    logic          tick;
    logic          ovf_pls;
    logic          ovf_flg;
    logic          cmp_match;
    logic          done;

    int checks = 0;
    int errors = 0;

    counter_timer #(.WIDTH(W), .PSC_W(PW)) dut (
        .i_sysclk    (clk),
        .i_sysrst    (rst),
        .i_cnt_en    (en),
        .i_ld        (ld),
        .i_ld_data   (ld_data),
        .i_clr       (clr),
        .i_dir       (dir),
        .i_mode      (mode),
        .i_top       (top),
        .i_cmp       (cmp),
        .i_psc       (psc),
        .i_ovf_ack   (ack),
        .o_cnt       (cnt),
        .o_tick      (tick),
        .o_ovf_pls   (ovf_pls),
        .o_ovf_flg   (ovf_flg),
        .o_cmp_match (cmp_match),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic          clr;
        logic          ld;
        logic [W-1:0]  ld_data;
        logic          en;
        logic          dir;
        logic [1:0]    mode;
        logic [W-1:0]  top;
        logic [W-1:0]  cmp;
        logic [PW-1:0] psc;
        logic          ack;
        logic [W-1:0]  e_cnt;
        logic          e_tick;
        logic          e_ovf;
        logic          e_flg;
        logic          e_match;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic l, logic [W-1:0] d, logic e, logic dr,
                                logic [1:0] m, logic [W-1:0] t, logic [W-1:0] cp,
                                logic [PW-1:0] p, logic a, logic [W-1:0] ec,
                                logic et, logic eo, logic ef, logic em, logic ed);
        vec_t v;
        v.clr = c; v.ld = l; v.ld_data = d; v.en = e; v.dir = dr; v.mode = m;
        v.top = t; v.cmp = cp; v.psc = p; v.ack = a; v.e_cnt = ec; v.e_tick = et;
        v.e_ovf = eo; v.e_flg = ef; v.e_match = em; v.e_done = ed;
        return v;
    endfunction

    function automatic logic [W+4:0] outs();
        return {cnt, tick, ovf_pls, ovf_flg, cmp_match, done};
    endfunction

    task automatic chk(input string nm, input logic [W+4:0] act, input logic [W+4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cnt/tick/ovf/flg/match/done=%h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; ld = 0; ld_data = '0; en = 0; ack = 0;
    endtask

    // Behavioural reference model state
    longint m_cnt;
    int     m_psc;
    bit     m_done;
    bit     m_flg;
    bit     m_tick, m_ovf, m_match;

    task automatic model_step();
        longint maxv;
        longint nxt;
        bit     wrapped;
        m_tick = 0; m_ovf = 0; m_match = 0;
        if (clr) begin
            m_cnt = 0; m_psc = 0; m_done = 0;
        end else if (ld) begin
            m_cnt = ld_data; m_psc = 0; m_done = 0; m_match = (ld_data == cmp);
        end else if (en && !m_done) begin
            if (m_psc >= int'(psc)) begin
                m_psc = 0;
                m_tick = 1;
                maxv = (mode == 2'd1 || mode == 2'd2) ? longint'(top) : (64'd1 << W) - 1;
                if (dir) begin
                    wrapped = (m_cnt >= maxv);
                    nxt = wrapped ? 0 : m_cnt + 1;
                end else begin
                    wrapped = (m_cnt == 0);
                    nxt = wrapped ? maxv : m_cnt - 1;
                end
                m_ovf = wrapped;
                if (wrapped && mode == 2'd2) begin
                    m_done = 1;
                end else begin
                    m_cnt = nxt;
                    m_match = (nxt == longint'(cmp));
                end
            end else begin
                m_psc++;
            end
        end
        if (m_ovf) m_flg = 1;
        else if (ack) m_flg = 0;
    endtask

    initial begin
        rst = 1; idle_inputs();
        dir = 1; mode = 2'b00; top = '0; cmp = '0; psc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), '0);
        rst = 0;

        // Reset asserted mid-count clears everything without waiting for an edge
        ld = 1; ld_data = 16'h1233; cmp = 16'h1234; cyc();
        ld = 0; en = 1; cyc();
        chk("pre_reset_count", outs(), {16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        en = 0;
        #2 rst = 1;
        #1 chk("async_reset_immediate", outs(), '0);
        @(posedge clk); #1;
        rst = 0;
        cyc();
        chk("after_reset_release", outs(), '0);

        // Directed vector table
        // A: free-run up wrap and flag acknowledge
        vecs.push_back(mk(0,1,16'hFFFE,1,1,0,0,16'h1234,0,0, 16'hFFFE,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,1,0,0,16'h1234,0,0, 16'hFFFF,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,1,0,0,16'h1234,0,0, 16'h0000,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,      0,1,0,0,16'h1234,0,0, 16'h0000,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,      0,1,0,0,16'h1234,0,1, 16'h0000,0,0,0,0,0));
        // B: modulo down, top=5, psc=2, from 1
        vecs.push_back(mk(0,1,16'h0001,1,0,1,5,4,2,0, 16'd1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd5,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd5,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd5,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd4,1,0,1,1,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd4,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd4,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,1,5,4,2,0, 16'd3,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,5,4,2,1, 16'd3,0,0,0,0,0));
        // C: priority of clr over ld, ld over tick, ovf set over ack
        vecs.push_back(mk(1,1,16'h00AA,0,1,0,0,16'h00AA,0,0, 16'h0000,0,0,0,0,0));
        vecs.push_back(mk(0,1,16'h00AA,1,1,0,0,16'h00AA,0,0, 16'h00AA,0,0,0,1,0));
        vecs.push_back(mk(0,1,16'hFFFF,0,1,0,0,16'h00AA,0,0, 16'hFFFF,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,       1,1,0,0,16'h00AA,0,1, 16'h0000,1,1,1,0,0));
        vecs.push_back(mk(0,0,0,       0,1,0,0,16'h00AA,0,1, 16'h0000,0,0,0,0,0));
        // D: load above top in modulo up wraps on the next tick
        vecs.push_back(mk(0,1,16'h0010,0,1,1,8,0,0,0, 16'h0010,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,       1,1,1,8,0,0,0, 16'h0000,1,1,1,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            clr = vecs[i].clr; ld = vecs[i].ld; ld_data = vecs[i].ld_data;
            en = vecs[i].en; dir = vecs[i].dir; mode = vecs[i].mode;
            top = vecs[i].top; cmp = vecs[i].cmp; psc = vecs[i].psc; ack = vecs[i].ack;
            cyc();
            chk($sformatf("vec_%0d", i), outs(),
                {vecs[i].e_cnt, vecs[i].e_tick, vecs[i].e_ovf, vecs[i].e_flg,
                 vecs[i].e_match, vecs[i].e_done});
        end

        // One-shot up to top=3, halt, then restart by load
        idle_inputs(); clr = 1; ack = 1; cyc();
        chk("oneshot_clear", outs(), '0);
        clr = 0; ack = 0; en = 1; dir = 1; mode = 2'b10; top = 16'd3; cmp = 16'd2; psc = 0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk($sformatf("oneshot_step_%0d", i), outs(),
                {16'(i), 1'b1, 1'b0, 1'b0, (i == 2), 1'b0});
        end
        cyc();
        chk("oneshot_terminal", outs(), {16'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("oneshot_hold_%0d", i), outs(), {16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        ld = 1; ld_data = '0; cyc();
        chk("oneshot_reload", outs(), {16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        ld = 0; cyc();
        chk("oneshot_restart", outs(), {16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        // Randomized traffic against the reference model
        idle_inputs(); clr = 1; ack = 1; psc = 0; cyc();
        chk("random_sync", outs(), '0);
        m_cnt = 0; m_psc = 0; m_done = 0; m_flg = 0;
        for (int i = 0; i < 4000; i++) begin
            clr = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 31) == 0);
            ld_data = ($urandom_range(0, 3) == 0) ? W'(16'hFFF0 + $urandom_range(0, 15))
                                                  : W'($urandom_range(0, 24));
            en  = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) top = W'($urandom_range(0, 20));
            if ($urandom_range(0, 31) == 0) cmp = W'($urandom_range(0, 20));
            if (clr) psc = PW'($urandom_range(0, 3));
            model_step();
            cyc();
            chk($sformatf("random_%0d", i), outs(),
                {W'(m_cnt), m_tick, m_ovf, m_flg, m_match, m_done});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
